// File: rtl/h_tdm_demux.sv
// h_tdm_demux: serial TDM bit stream to four 8-bit channels; define H_TDM_DEMUX_PARITY_EN for a 33rd even-parity bit and a parity_err pulse.
module h_tdm_demux (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       in_valid,
    input  logic       frame_sync,
    output logic [7:0] ch0,
    output logic [7:0] ch1,
    output logic [7:0] ch2,
    output logic [7:0] ch3,
    output logic       out_valid,
`ifdef H_TDM_DEMUX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);
`ifdef H_TDM_DEMUX_PARITY_EN
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST = 6'd32;
`else
    localparam int CW = 5;
    localparam logic [CW-1:0] LAST = 5'd31;
`endif
    typedef enum logic {HUNT, RECV} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   shadow_q, shadow_d, chs_q, chs_d, word;
    logic          out_valid_q, out_valid_d, frame_err_q, frame_err_d;
    logic          start, last, good;
    assign start = in_valid && frame_sync;
    assign last  = in_valid && !frame_sync && state_q == RECV && cnt_q == LAST;
`ifdef H_TDM_DEMUX_PARITY_EN
    logic parity_err_q, parity_err_d;
    // bit 32 is parity only; the data word is already complete in the shadow register
    assign word       = shadow_q;
    assign good       = ~^{shadow_q, in};
    assign parity_err = parity_err_q;
`else
    assign word = {shadow_q[30:0], in};
    assign good = 1'b1;
`endif
    assign {ch0, ch1, ch2, ch3} = chs_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    always_comb state_d = start ? RECV : last ? HUNT : state_q;

    always_comb begin
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        chs_d       = chs_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef H_TDM_DEMUX_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (start) begin
            // a sync always restarts the frame; inside RECV it also flags the abandoned one
            cnt_d       = CW'(1);
            shadow_d    = {31'd0, in};
            frame_err_d = state_q == RECV;
        end else if (last) begin
            cnt_d       = '0;
            shadow_d    = '0;
            chs_d       = good ? word : chs_q;
            out_valid_d = good;
`ifdef H_TDM_DEMUX_PARITY_EN
            parity_err_d = !good;
`endif
        end else if (in_valid && state_q == RECV) begin
            cnt_d    = cnt_q + CW'(1);
            shadow_d = {shadow_q[30:0], in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shadow_q    <= '0;
            chs_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef H_TDM_DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            chs_q       <= chs_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
`ifdef H_TDM_DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_h_tdm_demux.sv
// tb_h_tdm_demux: directed frames; expected pulses queued by stimulus and checked by a separate monitor.
module tb_h_tdm_demux;
`ifdef H_TDM_DEMUX_PARITY_EN
    localparam int NB = 33;
    logic parity_err;
`else
    localparam int NB = 32;
`endif
    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } ev_t;
    logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, in_valid = 1'b0, frame_sync = 1'b0;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic out_valid, frame_err;
    int cyc = 0, tests = 0, fails = 0;
    logic [31:0] model_ch = '0;
    ev_t exp_q[$];

    h_tdm_demux dut (
        .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .frame_sync(frame_sync),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3), .out_valid(out_valid),
`ifdef H_TDM_DEMUX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_pulse_kind", kind, 32'hffff_ffff);
            return;
        end
        e = exp_q.pop_front();
        chk("pulse_kind", kind, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        chk("channels", {ch0, ch1, ch2, ch3}, e.data);
    endtask

    always @(negedge clk) if (rst_n) begin
        if (out_valid && frame_err) chk("valid_and_err_together", 1, 0);
        if (out_valid) take(0);
        if (frame_err) take(1);
`ifdef H_TDM_DEMUX_PARITY_EN
        if (parity_err) take(2);
`endif
    end

    task automatic send_bit(input logic b, input logic s);
        @(posedge clk);
        #1 din = b; frame_sync = s; in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 in_valid = 1'b0; frame_sync = 1'b0;
        end
    endtask

    task automatic partial(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[31-i], i == 0);
    endtask

    task automatic send_frame(input logic [31:0] w, input int ga, input int gb, input bit err, input bit bad);
        int c0;
        for (int i = 0; i < 32; i++) begin
            send_bit(w[31-i], i == 0);
            if (i == 0) begin
                c0 = cyc;
                if (err) exp_q.push_back('{1, model_ch, c0 + 1});
                if (bad) exp_q.push_back('{2, model_ch, c0 + NB + ga + gb});
                else begin
                    exp_q.push_back('{0, w, c0 + NB + ga + gb});
                    model_ch = w;
                end
            end
            if (i == 5) idle(ga);
            if (i == 20) idle(gb);
        end
`ifdef H_TDM_DEMUX_PARITY_EN
        send_bit((^w) ^ bad, 1'b0);
`endif
    endtask

    initial begin
        #2;
        chk("reset_channels", {ch0, ch1, ch2, ch3}, 32'h0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        #10 rst_n = 1'b1;
        send_frame(32'hA55A_0FF0, 0, 0, 0, 0);
        idle(2);
        send_frame(32'hA55A_0FF0, 3, 3, 0, 0);
        idle(2);
        for (int i = 0; i < 40; i++) send_bit(i % 3 == 0, 1'b0);
        send_frame(32'h0102_0304, 0, 0, 0, 0);
        idle(2);
        partial(32'h1357_9BDF, 12);
        send_frame(32'hDEAD_BEEF, 0, 0, 1, 0);
        idle(2);
        partial(32'h1122_3344, 31);
        send_frame(32'h5566_7788, 0, 0, 1, 0);
        idle(2);
        partial(32'h1234_5678, 17);
        #3 in_valid = 1'b0; frame_sync = 1'b0; rst_n = 1'b0;
        #1;
        chk("async_reset_channels", {ch0, ch1, ch2, ch3}, 32'h0);
        chk("async_reset_out_valid", out_valid, 0);
        model_ch = '0;
        @(posedge clk);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) send_bit(1'b1, 1'b0);
        send_frame(32'hCAFE_F00D, 0, 0, 0, 0);
        idle(2);
`ifdef H_TDM_DEMUX_PARITY_EN
        send_frame(32'h0000_0001, 0, 0, 0, 0);
        send_frame(32'h0000_0001, 0, 0, 0, 1);
        send_frame(32'h0F0F_0F0F, 0, 0, 0, 1);
        idle(2);
`endif
        idle(5);
        chk("pending_expected_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
